// File: rtl/regfile_pkg.sv
// Shared constants and address-compare helper for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Widest address the shared compare helper handles; callers zero-extend into it.
    localparam int MAX_ADDR_W = 16;

    typedef logic [MAX_ADDR_W-1:0] addr_t;

    // True when an enabled write/clear at wa targets read address ra.
    // With zero_reg set, address 0 never matches, so neither bypass nor
    // scoreboard clear can ever touch the hardwired zero register.
    function automatic logic addr_hit(
        input logic  en,
        input addr_t wa,
        input addr_t ra,
        input logic  zero_reg
    );
        return en && (wa == ra) && !(zero_reg && (ra == '0));
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Load scoreboard: per-register busy bits, set/clear priority, occupancy
// counter and the per-read-port busy lookup used by the hazard unit.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rdaddr,
    output logic [NRD-1:0]        rdbusy,
    input  logic                  clr_en,
    input  logic [ADDR_W-1:0]     clr_addr,
    input  logic                  set_en,
    input  logic [ADDR_W-1:0]     set_addr,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int   DEPTH = 1 << ADDR_W;
    localparam int   CNT_W = ADDR_W + 1;
    localparam logic ZR    = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic set_eff;
    logic clr_eff;
    logic inc;
    logic dec;

    // Qualify set/clear; the zero register is never tracked when hardwired.
    always_comb begin
        set_eff = set_en && !(ZR && (set_addr == '0));
        clr_eff = clr_en && !(ZR && (clr_addr == '0));
    end

    // Next busy vector: clear first, then set, so a same-edge load issue wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_eff) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_eff) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    // Counter steps only on real transitions so it tracks popcount(busy).
    // A clear overridden by a set on the same address is not a transition.
    always_comb begin
        inc   = set_eff && !busy_q[set_addr];
        dec   = clr_eff && busy_q[clr_addr] && !(set_eff && (set_addr == clr_addr));
        cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
    end

    // Scoreboard state; pending marks/clears on a reset edge are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    // A writeback landing this cycle already resolves the hazard, so the
    // clear is forwarded; a mark only shows after it is registered.
    for (genvar k = 0; k < NRD; k++) begin : g_busy
        logic [ADDR_W-1:0] ra;
        assign ra        = rdaddr[k*ADDR_W +: ADDR_W];
        assign rdbusy[k] = busy_q[ra] & ~addr_hit(clr_en, addr_t'(clr_addr), addr_t'(ra), ZR);
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage: NRD combinational read
// ports with optional same-cycle bypass, ALU (port 0) and load (port 1)
// writeback ports, hardwired zero register and a load scoreboard.
//
// There is no handshake: every write, mark and read is accepted each cycle
// and nothing back-pressures the pipeline.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rdaddr,
    output logic [NRD*DATA_W-1:0] rddata,
    output logic [NRD-1:0]        rdbusy,
    input  logic                  RegWrite0,
    input  logic [ADDR_W-1:0]     wraddr0,
    input  logic [DATA_W-1:0]     wrdata0,
    input  logic                  RegWrite1,
    input  logic [ADDR_W-1:0]     wraddr1,
    input  logic [DATA_W-1:0]     wrdata1,
    input  logic                  mark,
    input  logic [ADDR_W-1:0]     mark_addr,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);
    localparam logic BP    = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic we0_eff;
    logic we1_eff;

    // Writes to the hardwired zero register are silently discarded.
    always_comb begin
        we0_eff = RegWrite0 && !(ZR && (wraddr0 == '0));
        we1_eff = RegWrite1 && !(ZR && (wraddr1 == '0));
    end

    // Next storage: port 1 applied last so a load wins an address collision.
    always_comb begin
        mem_d = mem_q;
        if (we0_eff) begin
            mem_d[wraddr0] = wrdata0;
        end
        if (we1_eff) begin
            mem_d[wraddr1] = wrdata1;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // One read mux per port; bypass priority mirrors the write priority.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              hit0;
        logic              hit1;

        assign ra   = rdaddr[k*ADDR_W +: ADDR_W];
        assign hit0 = addr_hit(RegWrite0, addr_t'(wraddr0), addr_t'(ra), ZR);
        assign hit1 = addr_hit(RegWrite1, addr_t'(wraddr1), addr_t'(ra), ZR);

        // Select bypass data or stored value; address 0 forced to zero.
        always_comb begin
            rd = mem_q[ra];
            if (BP) begin
                if (hit1) begin
                    rd = wrdata1;
                end else if (hit0) begin
                    rd = wrdata0;
                end
            end
            if (ZR && (ra == '0)) begin
                rd = '0;
            end
        end

        assign rddata[k*DATA_W +: DATA_W] = rd;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .rdaddr   (rdaddr),
        .rdbusy   (rdbusy),
        .clr_en   (RegWrite1),
        .clr_addr (wraddr1),
        .set_en   (mark),
        .set_addr (mark_addr),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS datapath: configurable width, depth and read-port count, two write ports (ALU and load writeback), same-cycle write-to-read bypass, hardwired zero register, and a load scoreboard of per-register busy bits with an occupancy counter. It sits in the decode stage: read ports feed operand fetch and busy flags feed the hazard/stall unit.

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; depth = 2**ADDR_W
- NRD, 2: number of read ports
- ZERO_REG, 1: when 1, register 0 always reads 0, ignores writes and is never marked busy
- BYPASS, 1: when 1, reads return same-cycle write data
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rdaddr  in  NRD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rddata  out  NRD*DATA_W  read data, packed the same way
- rdbusy  out  NRD  busy flag of each addressed register
- RegWrite0, wraddr0, wrdata0  in  1/ADDR_W/DATA_W  write port 0 (ALU writeback)
- RegWrite1, wraddr1, wrdata1  in  1/ADDR_W/DATA_W  write port 1 (load writeback); clears busy
- mark, mark_addr  in  1/ADDR_W  set busy on mark_addr (load issue)
- busy_cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- Writes: at rising clock edge, each enabled port writes its register. If both ports target the same address, port 1 data is stored.
- Reads: combinational. With BYPASS=1, if port 1 writes the read address this cycle, return wrdata1; else if port 0 writes it, return wrdata0; else return stored value. With BYPASS=0, return the stored value only.
- Zero register: with ZERO_REG=1, address 0 reads 0 including bypass, writes are discarded, and mark with mark_addr=0 has no effect.
- Scoreboard: at rising edge, a RegWrite1 write clears busy[wraddr1], and mark sets busy[mark_addr]. If both hit the same address, set wins because a new load was issued. RegWrite0 never changes busy.
- rdbusy[k] = busy[a] & ~(RegWrite1 & wraddr1==a), where a is the port-k address. A same-cycle mark is not visible until the next cycle.
- busy_cnt: registered. Each edge it changes by +1 (set of a non-busy register), −1 (clear of a busy register), 0 for both or neither. It always equals the popcount of busy and never wraps.
- Redundant events are no-ops for the count: marking an already-busy register, or clearing a non-busy one.

## Timing
- Reset asserted: asynchronously, with no clock, all registers become 0, all busy bits 0, and busy_cnt = 0. rddata then reads 0 unless bypass is active, and rdbusy = 0.
- Reset released: the first edge with reset low performs normal writes and marks.
- Reset mid-operation: pending writes and marks on that edge are discarded.
- Write latency: data is visible in storage one edge later. With BYPASS=1 it is visible on rddata in the same cycle.
- Scoreboard latency: mark is visible on rdbusy and busy_cnt after 1 edge. A port-1 clear is visible on rdbusy in the same cycle and on busy_cnt after 1 edge.
- No handshake: every request is accepted every cycle, and there is no backpressure.

## Structure
- Package regfile_pkg holds the default DATA_W and ADDR_W constants, and the helper function addr_hit(en, wa, ra, zero_reg) shared by bypass and scoreboard compares.
- Sub-module rf_scoreboard holds the busy vector, the set/clear priority, busy_cnt, and the rdbusy lookup.
- The top level holds the storage array, write priority, and the bypass read muxes, generated over NRD.

## Test plan
- Reset then writes: pulse reset at t=3..8, then write r1=100, r4=5, r8=333, r16=2000 via port 0 on consecutive edges → reading r1, r4, r8, r16 returns 100, 5, 333, 2000; reading r24 returns 0.
- Bypass and collision: same cycle port 0 writes r5=7, port 1 writes r5=9, and read r5 → rddata=9 in that cycle, storage holds 9 afterwards. With BYPASS=0, the same-cycle read returns the old value 0.
- Zero register: write r0=0xDEADBEEF and mark r0 → r0 reads 0, rdbusy=0, busy_cnt stays 0.
- Scoreboard: mark r3, then r7 → busy_cnt=2 and rdbusy=1 for r3. Port-1 write r3=42 → rdbusy for r3 is 0 in that cycle, busy_cnt=1 next cycle. Mark r7 and port-1 write r7 on the same edge → r7 stays busy, busy_cnt=1.
- Parameter sweep: instantiate with DATA_W=16, ADDR_W=3, NRD=4, all 4 ports reading distinct addresses after 8 writes → each port returns its own register. Mark all 7 nonzero registers → busy_cnt=7.
- Async reset mid-operation: with r1=100 and 3 registers busy, assert reset between edges → rddata=0 and busy_cnt=0 immediately, without waiting for a clock edge.
